mcs4_prog_rom: RTL and testbench
================================

Name: mcs4_prog_rom

Overview:
- MCS-4 program-memory responder: answers i4004 instruction fetches on the 4-bit multiplexed bus.
- Backed by a host-writable byte array, so a test program (e.g. LDM 5 / XCH R2 / NOP = D5 B2 00) is loaded from the PYNQ side without resynthesis.
- Drop-in for i4001's instruction-fetch role only; it has no I/O port.
- Sits beside i4002/i4004 on the shared dbus, sync, cm_rom and clken_1/clken_2 nets.

Parameters:
- NUM_PAGES, 1, number of 256-byte pages implemented (1..16).
- PAGE_BASE, 0, first A3 page number this block answers.
- CNT_W, 16, width of fetch_count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clken_1  in  1  phase-1 enable pulse, one clk wide
- clken_2  in  1  phase-2 enable pulse, one clk wide; all bus sampling and subcycle advance happen on it
- sync  in  1  CPU cycle marker, high during X3
- cm_rom  in  1  ROM command line, sampled in A3
- dbus_in  in  4  CPU bus output (mcs4::char_t)
- dbus_out  out  4  ROM bus drive (mcs4::char_t)
- dbus_oe  out  1  high while dbus_out is valid (M1/M2)
- prog_we  in  1  host write strobe
- prog_addr  in  8+$clog2(NUM_PAGES)  host byte address
- prog_wdata  in  8  host write byte
- fetch_strobe  out  1  one-clk pulse per serviced fetch
- fetch_addr  out  12  address of the last serviced fetch
- fetch_data  out  8  byte returned for that fetch
- fetch_count  out  CNT_W  serviced fetches since reset; wraps

Behaviour:
- Reset values: dbus_out=0, dbus_oe=0, fetch_strobe=0, fetch_addr=0, fetch_data=0, fetch_count=0, subcycle=IDLE, address latch=0. Memory is not cleared.
- Subcycle FSM states: IDLE, A1, A2, A3, M1, M2, X1, X2, X3.
  - Advances only on clk edges where clken_2=1.
  - On such an edge, sync=1 forces next=A1 from any state.
  - Otherwise it steps A1→A2→…→X3; X3 without sync → IDLE.
  - IDLE holds until sync.
- Address capture on clken_2 edges:
  - In A1, dbus_in → addr[3:0].
  - In A2, dbus_in → addr[7:4].
  - In A3, dbus_in → addr[11:8]; cm_rom is sampled at the same time.
- Select condition, evaluated at the A3 edge: cm_rom=1 and PAGE_BASE ≤ addr[11:8] < PAGE_BASE+NUM_PAGES.
  - If selected: mem[(page-PAGE_BASE)*256 + addr[7:0]] is latched into the fetch register on that edge.
  - Read-before-write: a host write to the same byte on the same clk yields the old byte.
- Bus drive, all registered, changing on the clken_2 edge that enters the named state:
  - Entering M1 (selected): dbus_out=byte[7:4] (OPR), dbus_oe=1.
  - Entering M2: dbus_out=byte[3:0] (OPA), dbus_oe=1.
  - Entering X1 or any other state: dbus_oe=0, dbus_out=0.
  - When not selected, dbus_oe stays 0 for the whole cycle.
- Fetch reporting: on the edge entering M1 for a selected cycle, fetch_strobe=1 for exactly one clk, fetch_addr/fetch_data update, and fetch_count increments (wraps at 2^CNT_W).
- Host writes: when prog_we=1, the write completes the same clk; it is accepted in any subcycle. Addresses ≥ NUM_PAGES*256 are ignored.
- Reset mid-cycle (e.g. during M1): the next clk forces dbus_oe=0 and state IDLE. The block then waits for sync; no partial drive resumes.
- Early sync (mid-cycle): resynchronises to A1 and abandons any in-progress fetch; no fetch_strobe if this happens before M1.
- clken_1 is accepted for interface symmetry only; no logic depends on it.

Decomposition:
- mcs4 package additions:
  - subcycle_t enum (IDLE, A1, A2, A3, M1, M2, X1, X2, X3).
  - PAGE_BYTES=256.
  - addr12_t.
  - Reuse existing char_t.
- Sub-module mcs4_subcycle_tracker (clk, rst, clken_2, sync → subcycle_t). Shared later with i4001/i4002 refactors.
- The memory array is inferred inside mcs4_prog_rom for a single-port-write / single-read BRAM.

Test Plan:
- Load D5@0x000, B2@0x001, 00@0x002; CPU-driven cycle with address 0x000, cm_rom=1 → M1 dbus_out=0xD, M2=0x5, dbus_oe high only in M1/M2; fetch_strobe once with fetch_addr=0x000, fetch_data=0xD5, fetch_count=1.
- Three back-to-back cycles at 0x000..0x002 → fetch_data sequence D5, B2, 00; fetch_count=3.
- cm_rom=0 at A3, or addr[11:8]=1 with NUM_PAGES=1 → dbus_oe stays 0; fetch_count unchanged.
- mem[0x001]=B2; host writes 0x7A to 0x001 on the A3 latch clk → that fetch returns B2, next fetch of 0x001 returns 7A.
- sync withheld after X3 → FSM in IDLE, no drive for the following 8 subcycles; sync restored → next fetch serviced normally.
- rst asserted during M1 → next clk dbus_oe=0, fetch_count=0, state IDLE; memory contents still D5/B2/00 on the next fetch.

Source files
------------

// File: rtl/mcs4_prog_rom_pkg.sv
// ---------------------------------------------------------------------------
// mcs4_prog_rom_pkg
// Shared MCS-4 bus types for the program-memory responder and its subcycle
// tracker: the 4-bit bus character, the 12-bit program address, the page
// size and the nine-state bus subcycle enumeration with its step function.
// No ports (package).
// ---------------------------------------------------------------------------
package mcs4_prog_rom_pkg;

   typedef logic [3:0]  char_t;
   typedef logic [11:0] addr12_t;

   localparam int PAGE_BYTES = 256;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      A1   = 4'd1,
      A2   = 4'd2,
      A3   = 4'd3,
      M1   = 4'd4,
      M2   = 4'd5,
      X1   = 4'd6,
      X2   = 4'd7,
      X3   = 4'd8
   } subcycle_t;

   // Free-running successor of a subcycle when sync is not asserted.
   // X3 without sync drops to IDLE; IDLE waits for sync.
   function automatic subcycle_t subcycle_step(input subcycle_t cur);
      subcycle_t nxt;
      case (cur)
         A1:      nxt = A2;
         A2:      nxt = A3;
         A3:      nxt = M1;
         M1:      nxt = M2;
         M2:      nxt = X1;
         X1:      nxt = X2;
         X2:      nxt = X3;
         X3:      nxt = IDLE;
         IDLE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mcs4_subcycle_tracker.sv
// ---------------------------------------------------------------------------
// mcs4_subcycle_tracker
// Follows the i4004 instruction cycle (A1..X3) from the sync marker.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (state -> IDLE)
//   clken_2  in   phase-2 enable; the state only moves on these edges
//   sync     in   cycle marker; forces A1 on the next clken_2 edge
//   subcycle out  current subcycle (registered)
// ---------------------------------------------------------------------------
module mcs4_subcycle_tracker
   import mcs4_prog_rom_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      clken_2,
   input  logic      sync,
   output subcycle_t subcycle
);

   subcycle_t subcycle_r;
   subcycle_t subcycle_next_s;

   // Next-state selection: sync wins from any state, otherwise step.
   always_comb begin
      subcycle_next_s = subcycle_r;
      if (clken_2) begin
         if (sync) begin
            subcycle_next_s = A1;
         end else begin
            subcycle_next_s = subcycle_step(subcycle_r);
         end
      end else begin
         subcycle_next_s = subcycle_r;
      end
   end

   // Subcycle state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         subcycle_r <= IDLE;
      end else begin
         subcycle_r <= subcycle_next_s;
      end
   end

   assign subcycle = subcycle_r;

endmodule

// File: rtl/mcs4_prog_rom.sv
// ---------------------------------------------------------------------------
// mcs4_prog_rom
// Host-loadable program memory that answers i4004 instruction fetches on
// the 4-bit multiplexed bus (fetch role of an i4001, no I/O port).
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   clken_1, clken_2    phase enables; only clken_2 edges do anything
//   sync, cm_rom        CPU cycle marker and ROM command line
//   dbus_in             CPU-driven bus nibble
//   dbus_out, dbus_oe   ROM bus drive, valid in M1 (OPR) and M2 (OPA)
//   prog_we/addr/wdata  host byte write port
//   fetch_strobe        one-clk pulse per serviced fetch
//   fetch_addr/data     address and byte of the last serviced fetch
//   fetch_count         serviced fetches since reset (wrapping)
// ---------------------------------------------------------------------------
module mcs4_prog_rom
   import mcs4_prog_rom_pkg::*;
#(
   parameter int NUM_PAGES = 1,
   parameter int PAGE_BASE = 0,
   parameter int CNT_W     = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clken_1,
   input  logic                             clken_2,
   input  logic                             sync,
   input  logic                             cm_rom,
   input  logic [3:0]                       dbus_in,
   output logic [3:0]                       dbus_out,
   output logic                             dbus_oe,
   input  logic                             prog_we,
   input  logic [8+$clog2(NUM_PAGES)-1:0]   prog_addr,
   input  logic [7:0]                       prog_wdata,
   output logic                             fetch_strobe,
   output logic [11:0]                      fetch_addr,
   output logic [7:0]                       fetch_data,
   output logic [CNT_W-1:0]                 fetch_count
);

   localparam int AW        = 8 + $clog2(NUM_PAGES);
   localparam int MEM_BYTES = NUM_PAGES * PAGE_BYTES;
   localparam logic [AW:0]      MEM_LIMIT = (AW+1)'(MEM_BYTES);
   localparam logic [5:0]       PAGE_LO   = 6'(PAGE_BASE);
   localparam logic [5:0]       PAGE_HI   = 6'(PAGE_BASE + NUM_PAGES);
   localparam char_t            PAGE_BASE_C = 4'(PAGE_BASE);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   subcycle_t        subcycle_s;
   logic [7:0]       mem_r [MEM_BYTES];
   logic [7:0]       addr_lo_r;
   logic             sel_r;
   logic [3:0]       dbus_out_r;
   logic             dbus_oe_r;
   logic             fetch_strobe_r;
   addr12_t          fetch_addr_r;
   logic [7:0]       fetch_data_r;
   logic [CNT_W-1:0] fetch_count_r;

   logic [5:0]       page_ext_s;
   logic             hit_s;
   char_t            page_off_s;
   logic [AW-1:0]    rd_idx_s;
   logic [7:0]       rd_byte_s;
   logic             wr_ok_s;
   logic             enter_m1_s;
   logic             enter_m2_s;
   logic             unused_clken_1_s;

   // clken_1 is part of the shared bus interface but carries no function here.
   assign unused_clken_1_s = clken_1;

   mcs4_subcycle_tracker u_tracker (
      .clk      (clk),
      .rst      (rst),
      .clken_2  (clken_2),
      .sync     (sync),
      .subcycle (subcycle_s)
   );

   // Page decode and read address; dbus_in carries addr[11:8] during A3.
   always_comb begin
      page_ext_s = {2'b00, dbus_in};
      hit_s      = cm_rom && (page_ext_s >= PAGE_LO) && (page_ext_s < PAGE_HI);
      page_off_s = dbus_in - PAGE_BASE_C;
      rd_idx_s   = AW'({page_off_s, addr_lo_r});
      wr_ok_s    = ({1'b0, prog_addr} < MEM_LIMIT);
      enter_m1_s = (subcycle_s == A3) && !sync;
      enter_m2_s = (subcycle_s == M1) && !sync;
      if (hit_s) begin
         rd_byte_s = mem_r[rd_idx_s];
      end else begin
         rd_byte_s = 8'h00;
      end
   end

   // Host write port; the array is never cleared. The fetch read above sees
   // the pre-write contents on a colliding clk.
   always_ff @(posedge clk) begin
      if (prog_we && wr_ok_s) begin
         mem_r[prog_addr] <= prog_wdata;
      end
   end

   // Address capture, bus drive and fetch reporting.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_lo_r      <= 8'h00;
         sel_r          <= 1'b0;
         dbus_out_r     <= 4'h0;
         dbus_oe_r      <= 1'b0;
         fetch_strobe_r <= 1'b0;
         fetch_addr_r   <= 12'h000;
         fetch_data_r   <= 8'h00;
         fetch_count_r  <= {CNT_W{1'b0}};
      end else begin
         fetch_strobe_r <= 1'b0;
         if (clken_2) begin
            case (subcycle_s)
               A1:      addr_lo_r[3:0] <= dbus_in;
               A2:      addr_lo_r[7:4] <= dbus_in;
               default: ;
            endcase
            // The A3 edge is also the edge entering M1, so the byte is read,
            // reported and its OPR nibble driven all at once.
            if (enter_m1_s && hit_s) begin
               sel_r          <= 1'b1;
               dbus_out_r     <= rd_byte_s[7:4];
               dbus_oe_r      <= 1'b1;
               fetch_strobe_r <= 1'b1;
               fetch_addr_r   <= {dbus_in, addr_lo_r};
               fetch_data_r   <= rd_byte_s;
               fetch_count_r  <= fetch_count_r + CNT_ONE;
            end else if (enter_m2_s && sel_r) begin
               sel_r      <= 1'b0;
               dbus_out_r <= fetch_data_r[3:0];
               dbus_oe_r  <= 1'b1;
            end else begin
               sel_r      <= 1'b0;
               dbus_out_r <= 4'h0;
               dbus_oe_r  <= 1'b0;
            end
         end
      end
   end

   assign dbus_out     = dbus_out_r;
   assign dbus_oe      = dbus_oe_r;
   assign fetch_strobe = fetch_strobe_r;
   assign fetch_addr   = fetch_addr_r;
   assign fetch_data   = fetch_data_r;
   assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_mcs4_prog_rom.sv
// ---------------------------------------------------------------------------
// tb_mcs4_prog_rom
// Drives i4004-style instruction cycles and host writes into mcs4_prog_rom
// and compares the bus drive and fetch reports against a byte-array model.
// ---------------------------------------------------------------------------
module tb_mcs4_prog_rom;
   import mcs4_prog_rom_pkg::*;

   logic        clk;
   logic        rst;
   logic        clken_1;
   logic        clken_2;
   logic        sync;
   logic        cm_rom;
   logic [3:0]  dbus_in;
   logic [3:0]  dbus_out;
   logic        dbus_oe;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [7:0]  prog_wdata;
   logic        fetch_strobe;
   logic [11:0] fetch_addr;
   logic [7:0]  fetch_data;
   logic [15:0] fetch_count;

   int          checks = 0;
   int          errors = 0;
   int          strobe_total = 0;
   int          exp_strobes = 0;
   int          exp_count = 0;
   logic [11:0] exp_addr = 12'h000;
   logic [7:0]  exp_data = 8'h00;
   logic [7:0]  model_mem [256];
   logic        wr_pend = 1'b0;
   logic [7:0]  wr_addr = 8'h00;
   logic [7:0]  wr_data = 8'h00;

   mcs4_prog_rom dut (
      .clk          (clk),
      .rst          (rst),
      .clken_1      (clken_1),
      .clken_2      (clken_2),
      .sync         (sync),
      .cm_rom       (cm_rom),
      .dbus_in      (dbus_in),
      .dbus_out     (dbus_out),
      .dbus_oe      (dbus_oe),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_wdata   (prog_wdata),
      .fetch_strobe (fetch_strobe),
      .fetch_addr   (fetch_addr),
      .fetch_data   (fetch_data),
      .fetch_count  (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every clk on which the strobe is high; a stuck strobe inflates it.
   always @(posedge clk) begin
      if (fetch_strobe === 1'b1) strobe_total <= strobe_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One bus subcycle: clken_1 clk, idle clk, clken_2 clk. Outputs are
   // stable #1 after the clken_2 edge when this returns.
   task automatic phase(input logic sy, input logic cm, input logic [3:0] d);
      sync = sy; cm_rom = cm; dbus_in = d; clken_1 = 1'b1;
      @(posedge clk); #1;
      clken_1 = 1'b0;
      @(posedge clk); #1;
      clken_2 = 1'b1;
      prog_we = wr_pend; prog_addr = wr_addr; prog_wdata = wr_data;
      @(posedge clk); #1;
      clken_2 = 1'b0; prog_we = 1'b0;
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      prog_we = 1'b1; prog_addr = a; prog_wdata = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
      model_mem[a] = d;
   endtask

   // Full instruction cycle starting with the sync subcycle; optional host
   // write on the A3 clk and optional stop right after entering M1.
   task automatic run_cycle(input logic [11:0] a, input logic cm, input logic wr_a3,
                            input logic [7:0] wa, input logic [7:0] wd, input logic stop_m1);
      logic       sel;
      logic [7:0] b;
      sel = cm && (a[11:8] == 4'h0);
      b   = model_mem[a[7:0]];
      phase(1'b1, 1'b0, 4'h0);
      phase(1'b0, 1'b0, a[3:0]);
      phase(1'b0, 1'b0, a[7:4]);
      wr_pend = wr_a3; wr_addr = wa; wr_data = wd;
      phase(1'b0, cm, a[11:8]);
      wr_pend = 1'b0;
      if (wr_a3) model_mem[wa] = wd;
      if (sel) begin
         exp_count = (exp_count + 1) & 32'h0000_FFFF;
         exp_addr  = a;
         exp_data  = b;
         exp_strobes++;
      end
      chk("m1_oe", 32'(dbus_oe), 32'(sel));
      chk("m1_out", 32'(dbus_out), sel ? 32'(b[7:4]) : 32'd0);
      chk("m1_strobe", 32'(fetch_strobe), 32'(sel));
      chk("fetch_addr", 32'(fetch_addr), 32'(exp_addr));
      chk("fetch_data", 32'(fetch_data), 32'(exp_data));
      chk("fetch_count", 32'(fetch_count), 32'(exp_count));
      if (!stop_m1) begin
         phase(1'b0, 1'b0, 4'h0);
         chk("m2_oe", 32'(dbus_oe), 32'(sel));
         chk("m2_out", 32'(dbus_out), sel ? 32'(b[3:0]) : 32'd0);
         chk("strobe_pulses", 32'(strobe_total), 32'(exp_strobes));
         phase(1'b0, 1'b0, 4'h0);
         chk("x1_oe", 32'(dbus_oe), 32'd0);
         chk("x1_out", 32'(dbus_out), 32'd0);
         phase(1'b0, 1'b0, 4'h0);
         phase(1'b0, 1'b0, 4'h0);
      end
   endtask

   initial begin
      logic [11:0] ra;
      logic        rcm;
      logic        rwr;
      logic [7:0]  rwa;
      logic [7:0]  rwd;

      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      rst = 1'b1; clken_1 = 1'b0; clken_2 = 1'b0; sync = 1'b0; cm_rom = 1'b0;
      dbus_in = 4'h0; prog_we = 1'b0; prog_addr = 8'h00; prog_wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_oe", 32'(dbus_oe), 32'd0);
      chk("rst_out", 32'(dbus_out), 32'd0);
      chk("rst_strobe", 32'(fetch_strobe), 32'd0);
      chk("rst_addr", 32'(fetch_addr), 32'd0);
      chk("rst_data", 32'(fetch_data), 32'd0);
      chk("rst_count", 32'(fetch_count), 32'd0);
      chk("rst_state", 32'(dut.u_tracker.subcycle), 32'(IDLE));
      rst = 1'b0;

      // Zero the array so the model and memory agree everywhere.
      for (int i = 0; i < 256; i++) host_write(8'(i), 8'h00);
      host_write(8'h00, 8'hD5);
      host_write(8'h01, 8'hB2);
      host_write(8'h02, 8'h00);

      // Single fetch, then three back-to-back.
      run_cycle(12'h000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) run_cycle(12'(i), 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

      // Not selected: cm_rom low, then a page outside the implemented range.
      run_cycle(12'h001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      run_cycle(12'h100, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

      // Host write on the A3 latch clk returns the old byte, then the new one.
      run_cycle(12'h001, 1'b1, 1'b1, 8'h01, 8'h7A, 1'b0);
      run_cycle(12'h001, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      host_write(8'h01, 8'hB2);

      // Sync withheld after X3: IDLE and silent.
      phase(1'b0, 1'b0, 4'h0);
      chk("idle_state", 32'(dut.u_tracker.subcycle), 32'(IDLE));
      for (int i = 0; i < 8; i++) begin
         phase(1'b0, 1'b1, 4'(i));
         chk("idle_oe", 32'(dbus_oe), 32'd0);
         chk("idle_hold", 32'(dut.u_tracker.subcycle), 32'(IDLE));
      end
      run_cycle(12'h002, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

      // Early sync at A3 abandons the fetch.
      phase(1'b1, 1'b0, 4'h0);
      phase(1'b0, 1'b0, 4'h0);
      phase(1'b0, 1'b0, 4'h0);
      phase(1'b1, 1'b1, 4'h0);
      chk("early_oe", 32'(dbus_oe), 32'd0);
      chk("early_strobe", 32'(fetch_strobe), 32'd0);
      chk("early_count", 32'(fetch_count), 32'(exp_count));
      chk("early_state", 32'(dut.u_tracker.subcycle), 32'(A1));

      // Reset while in M1.
      run_cycle(12'h000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_count = 0; exp_addr = 12'h000; exp_data = 8'h00;
      chk("mrst_oe", 32'(dbus_oe), 32'd0);
      chk("mrst_count", 32'(fetch_count), 32'd0);
      chk("mrst_state", 32'(dut.u_tracker.subcycle), 32'(IDLE));
      phase(1'b0, 1'b0, 4'h0);
      chk("mrst_no_resume", 32'(dbus_oe), 32'd0);
      for (int i = 0; i < 3; i++) run_cycle(12'(i), 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

      // Randomized cycles with interleaved host writes.
      for (int i = 0; i < 40; i++) begin
         ra  = 12'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) ra[11:8] = 4'($urandom_range(1, 15));
         rcm = ($urandom_range(0, 4) != 0);
         rwr = ($urandom_range(0, 3) == 0);
         rwa = 8'($urandom_range(0, 255));
         rwd = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) host_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         run_cycle(ra, rcm, rwr, rwa, rwd, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
